// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: coordinate width, default 640x480@60 timing
// constants, the registered flag bundle and a window-compare helper.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 11;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  // Per-pixel flags registered alongside the coordinates.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  // True when lo <= v < hi_excl.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi_excl);
    return (v >= lo) && (v < hi_excl);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) counter; reset loads MAX so the first increment lands on 0.
// Ports: clk, rst_n (async, active-low, loads MAX), inc (advance one step),
//        count (registered value), wrap (inc while at MAX),
//        count_next_c (value count takes at the next clk).
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX = 799
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  output coord_t count,
  output logic   wrap,
  output coord_t count_next_c
);

  coord_t count_q;
  coord_t count_d;
  logic   at_max;

  // Next-count and wrap decode.
  always_comb begin
    at_max  = (count_q == COORD_W'(MAX));
    count_d = count_q;
    wrap    = 1'b0;
    if (inc) begin
      wrap    = at_max;
      count_d = at_max ? '0 : count_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= COORD_W'(MAX);
    end else begin
      count_q <= count_d;
    end
  end

  assign count        = count_q;
  assign count_next_c = count_d;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. Horizontal and vertical wrap counters produce
// the pixel position; all flags are computed from the next-state coordinates
// so they are registered in the same cycle as the x/y they describe.
// Ports: clk, rst_n (async active-low), ce (pixel enable),
//        x/y (current coordinates), de (visible area), hsync/vsync (SYNC_POL
//        when asserted), line_start/frame_start (one-cycle entry pulses).
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  coord_t     x_cnt;
  coord_t     y_cnt;
  coord_t     x_nxt;
  coord_t     y_nxt;
  logic       h_wrap;
  logic       v_wrap;
  vga_flags_t flags_d;
  vga_flags_t flags_q;

  // Horizontal axis advances on every enabled pixel.
  wrap_counter #(
    .MAX (H_TOTAL - 1)
  ) u_h_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (ce),
    .count        (x_cnt),
    .wrap         (h_wrap),
    .count_next_c (x_nxt)
  );

  // Vertical axis advances only when the line wraps.
  wrap_counter #(
    .MAX (V_TOTAL - 1)
  ) u_v_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (h_wrap),
    .count        (y_cnt),
    .wrap         (v_wrap),
    .count_next_c (y_nxt)
  );

  // Flags decoded from the next coordinates; with ce=0 the next coordinates
  // equal the current ones, so the level flags hold and the pulses drop.
  always_comb begin
    flags_d             = '0;
    flags_d.de          = (x_nxt < COORD_W'(H_ACTIVE)) && (y_nxt < COORD_W'(V_ACTIVE));
    flags_d.hsync       = in_window(x_nxt, COORD_W'(HS_START), COORD_W'(HS_END))
                          ? SYNC_POL : ~SYNC_POL;
    flags_d.vsync       = in_window(y_nxt, COORD_W'(VS_START), COORD_W'(VS_END))
                          ? SYNC_POL : ~SYNC_POL;
    flags_d.line_start  = h_wrap;
    flags_d.frame_start = h_wrap & v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q             <= '0;
      flags_q.hsync       <= ~SYNC_POL;
      flags_q.vsync       <= ~SYNC_POL;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign x           = x_cnt;
  assign y           = y_cnt;
  assign de          = flags_q.de;
  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels; H_TOTAL = sum of the four, default 800.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical equivalents in lines; V_TOTAL default 525.
REQ-006 Parameter SYNC_POL, default 0, asserted level of hsync and vsync.
REQ-007 clk  input  1  pixel-domain clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 ce  input  1  pixel clock enable; timing advances one pixel per clk with ce=1.
REQ-010 x  output  11  current horizontal count, 0..H_TOTAL-1.
REQ-011 y  output  11  current vertical count, 0..V_TOTAL-1.
REQ-012 de  output  1  display enable, high when (x,y) is visible.
REQ-013 hsync  output  1  horizontal sync at SYNC_POL when asserted.
REQ-014 vsync  output  1  vertical sync at SYNC_POL when asserted.
REQ-015 line_start  output  1  one-cycle pulse on entry to x=0.
REQ-016 frame_start  output  1  one-cycle pulse on entry to (x,y)=(0,0).

Function
REQ-017 With ce=1, x shall increment by 1 per clk and wrap from H_TOTAL-1 to 0.
REQ-018 y shall increment by 1 exactly on the clk where x wraps, and wrap from V_TOTAL-1 to 0 on the same clk x wraps.
REQ-019 With ce=0, x, y, de, hsync and vsync shall hold; line_start and frame_start shall be 0.
REQ-020 de shall be 1 iff x < H_ACTIVE and y < V_ACTIVE.
REQ-021 hsync shall be asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
REQ-022 vsync shall be asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491), independent of x.
REQ-023 All outputs shall be registered, with zero relative skew: de, hsync, vsync and the pulses shall describe the x,y values presented in the same cycle.
REQ-024 line_start shall be 1 in the single cycle where x has just become 0 via a ce step, and 0 otherwise.
REQ-025 frame_start shall be 1 in the single cycle where (x,y) has just become (0,0) via a ce step; it coincides with line_start.
REQ-026 Arithmetic shall be unsigned 11-bit; totals up to 2047 shall be supported without overflow.

Reset
REQ-027 While rst_n=0: x=H_TOTAL-1, y=V_TOTAL-1, de=0, hsync=vsync=~SYNC_POL, line_start=frame_start=0.
REQ-028 The first ce=1 clk after rst_n release shall move to (0,0) with de=1, line_start=1 and frame_start=1.
REQ-029 Asserting rst_n mid-frame shall force the REQ-027 values immediately, without waiting for clk.

Structure
REQ-030 Default timing constants and the 11-bit coordinate width shall reside in package vga_timing_pkg, shared with the sprite and game-logic blocks.
REQ-031 One sub-module wrap_counter (parameter MAX, inputs inc and load-to-MAX reset, outputs count and wrap) shall be instantiated once per axis.

Verification
REQ-032 Reset, release, ce=1 -> first cycle x=0, y=0, de=1, line_start=1, frame_start=1; next cycle x=1, both pulses 0.
REQ-033 ce=1 for one line -> hsync asserted for exactly 96 cycles, first at x=656; de=1 for exactly 640 cycles; x=799 is followed by x=0 with y+1.
REQ-034 Full frame of 420000 ce cycles -> exactly one frame_start, 525 line_start pulses, vsync asserted for 1600 cycles starting at (0,490), 307200 de cycles.
REQ-035 ce toggled 1,0,0,1 at x=10 -> x sequence 11,11,11,12; no pulses while ce=0.
REQ-036 rst_n pulled low at (x,y)=(300,200) -> outputs equal REQ-027 values before the next clk edge; frame resumes at (0,0) after release.
REQ-037 SYNC_POL=1 build -> hsync high only for x in 656..751 and vsync high only for y in 490..491; reset level of both is 0.
